// File: rtl/cargador_serial_izq_der_pkg.sv
// Shared encodings for the bit-serial loader and the left-to-right compare cell.
package cargador_serial_izq_der_pkg;

  localparam int unsigned N_DEFAULT = 4;

  localparam logic [0:0] RECIBIR = 1'b0;
  localparam logic [0:0] LISTO   = 1'b1;

  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_LT = 2'b01;
  localparam logic [1:0] CMP_GT = 2'b10;

endpackage

// File: rtl/cargador_serial_izq_der_if.sv
// Bit-pair input handshake and parallel word output bundle.
interface cargador_serial_izq_der_if #(
  parameter int unsigned N = 4
);
  logic         bit_valid;
  logic         bit_ready;
  logic         a_bit;
  logic         b_bit;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Zser;
  logic         word_valid;
  logic         word_ack;

  modport master (
    output bit_valid, a_bit, b_bit, word_ack,
    input  bit_ready, A, B, Zser, word_valid
  );

  modport slave (
    input  bit_valid, a_bit, b_bit, word_ack,
    output bit_ready, A, B, Zser, word_valid
  );
endinterface

// File: rtl/celda_comp_izqder.sv
// One cell of the left-to-right comparison network: first differing bit decides.
module celda_comp_izqder
  import cargador_serial_izq_der_pkg::*;
(
  input  logic [1:0] cmp_in,
  input  logic       a,
  input  logic       b,
  output logic [1:0] cmp_out
);

  always_comb begin
    cmp_out = cmp_in;
    if (cmp_in == CMP_EQ) begin
      if (!a && b) begin
        cmp_out = CMP_LT;
      end else if (a && !b) begin
        cmp_out = CMP_GT;
      end
    end
  end

endmodule

// File: rtl/cargador_serial_izq_der.sv
// Serial-to-parallel loader for A/B with a sequential A<=B result (Zser).
module cargador_serial_izq_der
  import cargador_serial_izq_der_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input logic                      clk,
  input logic                      rst_n,
  cargador_serial_izq_der_if.slave bus
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    cmp_q, cmp_d, cmp_nxt;
  logic [N-1:0]  sha_q, sha_d, shb_q, shb_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d;
  logic          zser_q, zser_d;
  logic          wv_q, wv_d;
  logic          xfer;

  celda_comp_izqder u_celda (
    .cmp_in  (cmp_q),
    .a       (bus.a_bit),
    .b       (bus.b_bit),
    .cmp_out (cmp_nxt)
  );

  assign xfer = bus.bit_valid && (state_q == RECIBIR);

  // Next-state: shift in on transfer, capture the word on the Nth bit, release on ack.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmp_d   = cmp_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    a_d     = a_q;
    b_d     = b_q;
    zser_d  = zser_q;
    wv_d    = wv_q;
    case (state_q)
      RECIBIR: begin
        if (xfer) begin
          sha_d = {sha_q[N-2:0], bus.a_bit};
          shb_d = {shb_q[N-2:0], bus.b_bit};
          cnt_d = cnt_q + CW'(1);
          cmp_d = cmp_nxt;
          if (cnt_q == CW'(N - 1)) begin
            a_d     = {sha_q[N-2:0], bus.a_bit};
            b_d     = {shb_q[N-2:0], bus.b_bit};
            zser_d  = (cmp_nxt != CMP_GT);
            wv_d    = 1'b1;
            state_d = LISTO;
          end
        end
      end
      default: begin
        if (bus.word_ack) begin
          state_d = RECIBIR;
          wv_d    = 1'b0;
          cnt_d   = '0;
          cmp_d   = CMP_EQ;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RECIBIR;
      cnt_q   <= '0;
      cmp_q   <= CMP_EQ;
      sha_q   <= '0;
      shb_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      zser_q  <= 1'b0;
      wv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      a_q     <= a_d;
      b_q     <= b_d;
      zser_q  <= zser_d;
      wv_q    <= wv_d;
    end
  end

  // bit_ready is a pure decode of the state register.
  assign bus.bit_ready  = (state_q == RECIBIR);
  assign bus.A          = a_q;
  assign bus.B          = b_q;
  assign bus.Zser       = zser_q;
  assign bus.word_valid = wv_q;

endmodule

// File: tb/tb_cargador_serial_izq_der.sv
// Self-checking bench for cargador_serial_izq_der with a word-level reference model.
module tb_cargador_serial_izq_der;

  localparam int unsigned N = 4;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  cargador_serial_izq_der_if #(.N(N)) bus ();

  cargador_serial_izq_der #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ref_z(input logic [N-1:0] a, input logic [N-1:0] b);
    return (a <= b);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic a, input logic b);
    int w;
    w = 0;
    while (bus.bit_ready !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    if (w >= 50) begin
      tests_run++; tests_failed++;
      $display("FAIL ready_timeout: bit_ready=%b required 1", bus.bit_ready);
    end
    bus.a_bit = a;
    bus.b_bit = b;
    bus.bit_valid = 1'b1;
    tick();
    bus.bit_valid = 1'b0;
  endtask

  task automatic send_word(input logic [N-1:0] a, input logic [N-1:0] b, input int gap);
    for (int i = N - 1; i >= 0; i--) begin
      send_bit(a[i], b[i]);
      if (i > 0) repeat (gap) tick();
    end
  endtask

  task automatic pulse_ack();
    bus.word_ack = 1'b1;
    tick();
    bus.word_ack = 1'b0;
    tests_run++;
    if (bus.word_valid !== 1'b0 || bus.bit_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL ack_release: word_valid=%b bit_ready=%b required 0 1", bus.word_valid, bus.bit_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    tests_run++;
    if (bus.A !== 4'h0 || bus.B !== 4'h0 || bus.Zser !== 1'b0 || bus.word_valid !== 1'b0 || bus.bit_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_state: A=%h B=%h Z=%b wv=%b rdy=%b required 0 0 0 0 1", bus.A, bus.B, bus.Zser, bus.word_valid, bus.bit_ready);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [N-1:0] a, b;
    a = 4'b1010; b = 4'b0100;
    for (int i = N - 1; i >= 1; i--) send_bit(a[i], b[i]);
    tests_run++;
    if (bus.word_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_early_valid: word_valid=%b required 0", bus.word_valid);
    end
    send_bit(a[0], b[0]);
    tests_run++;
    if (bus.word_valid !== 1'b1 || bus.A !== 4'hA || bus.B !== 4'h4 || bus.Zser !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_word: wv=%b A=%h B=%h Z=%b required 1 a 4 0", bus.word_valid, bus.A, bus.B, bus.Zser);
    end
    pulse_ack();
  endtask

  task automatic test_gaps();
    logic [N-1:0] a, b;
    a = 4'b0011; b = 4'b0100;
    for (int i = N - 1; i >= 0; i--) begin
      send_bit(a[i], b[i]);
      if (i > 0) begin
        repeat (2) begin
          tick();
          tests_run++;
          if (bus.word_valid !== 1'b0 || bus.bit_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL gap_stall: wv=%b rdy=%b required 0 1", bus.word_valid, bus.bit_ready);
          end
        end
      end
    end
    tests_run++;
    if (bus.word_valid !== 1'b1 || bus.A !== 4'h3 || bus.B !== 4'h4 || bus.Zser !== 1'b1) begin
      tests_failed++;
      $display("FAIL gap_word: wv=%b A=%h B=%h Z=%b required 1 3 4 1", bus.word_valid, bus.A, bus.B, bus.Zser);
    end
    pulse_ack();
  endtask

  task automatic test_reset_midword();
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.A !== 4'h0 || bus.B !== 4'h0 || bus.Zser !== 1'b0 || bus.word_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midword_reset: A=%h B=%h Z=%b wv=%b required 0 0 0 0", bus.A, bus.B, bus.Zser, bus.word_valid);
    end
    tick();
    rst_n = 1'b1;
    tick();
    send_word(4'b0101, 4'b0110, 0);
    tests_run++;
    if (bus.word_valid !== 1'b1 || bus.A !== 4'h5 || bus.B !== 4'h6 || bus.Zser !== 1'b1) begin
      tests_failed++;
      $display("FAIL post_reset_word: wv=%b A=%h B=%h Z=%b required 1 5 6 1", bus.word_valid, bus.A, bus.B, bus.Zser);
    end
    pulse_ack();
  endtask

  task automatic test_hold();
    send_word(4'b1000, 4'b0000, 0);
    for (int c = 0; c < 5; c++) begin
      bus.bit_valid = 1'b1;
      bus.a_bit = 1'($urandom);
      bus.b_bit = 1'($urandom);
      tick();
      tests_run++;
      if (bus.bit_ready !== 1'b0 || bus.word_valid !== 1'b1 || bus.A !== 4'h8 || bus.B !== 4'h0 || bus.Zser !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold_frozen: rdy=%b wv=%b A=%h B=%h Z=%b required 0 1 8 0 0", bus.bit_ready, bus.word_valid, bus.A, bus.B, bus.Zser);
      end
    end
    bus.bit_valid = 1'b0;
    pulse_ack();
  endtask

  task automatic test_equal();
    send_word(4'b0000, 4'b0000, 0);
    tests_run++;
    if (bus.word_valid !== 1'b1 || bus.Zser !== 1'b1) begin
      tests_failed++;
      $display("FAIL equal_zser: wv=%b Z=%b required 1 1", bus.word_valid, bus.Zser);
    end
    pulse_ack();
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] a, b;
    bus.word_ack = 1'b1;
    for (int w = 0; w < 3; w++) begin
      a = N'($urandom);
      b = N'($urandom);
      send_word(a, b, 0);
      tests_run++;
      if (bus.word_valid !== 1'b1 || bus.A !== a || bus.B !== b || bus.Zser !== ref_z(a, b)) begin
        tests_failed++;
        $display("FAIL b2b_word%0d: wv=%b A=%h B=%h Z=%b required 1 %h %h %b", w, bus.word_valid, bus.A, bus.B, bus.Zser, a, b, ref_z(a, b));
      end
      tick();
      tests_run++;
      if (bus.word_valid !== 1'b0 || bus.bit_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL b2b_pulse%0d: wv=%b rdy=%b required 0 1", w, bus.word_valid, bus.bit_ready);
      end
    end
    bus.word_ack = 1'b0;
  endtask

  task automatic test_random();
    logic [N-1:0] a, b;
    int hold;
    for (int w = 0; w < 20; w++) begin
      a = N'($urandom);
      b = N'($urandom);
      if (w == 0) b = a;
      send_word(a, b, int'($urandom_range(0, 2)));
      hold = int'($urandom_range(0, 3));
      repeat (hold) tick();
      tests_run++;
      if (bus.word_valid !== 1'b1 || bus.A !== a || bus.B !== b || bus.Zser !== ref_z(a, b)) begin
        tests_failed++;
        $display("FAIL rand_word%0d: wv=%b A=%h B=%h Z=%b required 1 %h %h %b", w, bus.word_valid, bus.A, bus.B, bus.Zser, a, b, ref_z(a, b));
      end
      pulse_ack();
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    bus.bit_valid = 1'b0;
    bus.a_bit = 1'b0;
    bus.b_bit = 1'b0;
    bus.word_ack = 1'b0;
    test_reset();
    test_basic();
    test_gaps();
    test_reset_midword();
    test_hold();
    test_equal();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
